traffic_phase_ctrl: RTL and testbench

//   Parametrised N-phase traffic-signal controller. It replaces the fixed 5-state, single-sensor sequencer.
//   Per-phase vehicle requests are latched. Phases are served round-robin with min/max green, yellow and
//   all-red timing. Rests in green when there is no competing demand. Emergency preemption forces a chosen phase.

---
 rtl/traffic_phase_ctrl.sv | 136 +++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-phase round-robin traffic-signal controller with
// min/max green, yellow and all-red timing, latched per-phase demand and
// emergency preemption. Rests in green while no other phase has demand.
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   req            per-phase vehicle detector (level)
//   preempt        emergency preemption request (level)
//   preempt_phase  phase to force while preempt=1 (ignored if >= NUM_PHASES)
//   green/yellow   one-hot lamp outputs, all zero outside their state
//   red            ~(green|yellow)
//   cur_phase      phase being served or cleared
//   state          00 GREEN, 01 YELLOW, 10 ALL_RED
//   pending        latched demand
// All outputs decode from registers only.
module traffic_phase_ctrl #(
  parameter int NUM_PHASES  = 4,
  parameter int CNT_W       = 8,
  parameter int T_MIN_GREEN = 8,
  parameter int T_MAX_GREEN = 20,
  parameter int T_YELLOW    = 3,
  parameter int T_ALL_RED   = 2,
  localparam int PH_W = ($clog2(NUM_PHASES) < 1) ? 1 : $clog2(NUM_PHASES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_PHASES-1:0] req,
  input  logic                  preempt,
  input  logic [PH_W-1:0]       preempt_phase,
  output logic [NUM_PHASES-1:0] green,
  output logic [NUM_PHASES-1:0] yellow,
  output logic [NUM_PHASES-1:0] red,
  output logic [PH_W-1:0]       cur_phase,
  output logic [1:0]            state,
  output logic [NUM_PHASES-1:0] pending
);

  typedef enum logic [1:0] {
    GREEN   = 2'b00,
    YELLOW  = 2'b01,
    ALL_RED = 2'b10
  } state_t;

  // Terminal timer values, sized to the timer so comparisons stay width-clean.
  localparam logic [CNT_W-1:0] MIN_G_LAST = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_G_LAST = CNT_W'(T_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(T_ALL_RED - 1);

  state_t                  st_q, st_d;
  logic [CNT_W-1:0]        timer_q, timer_d;
  logic [PH_W-1:0]         cur_q, cur_d;
  logic [NUM_PHASES-1:0]   pend_q, pend_d;
  logic [NUM_PHASES-1:0]   cur_oh;
  logic [PH_W-1:0]         nxt_phase;
  logic                    pv;
  logic                    other;

  // (p + k) mod NUM_PHASES
  function automatic logic [PH_W-1:0] ph_add(input logic [PH_W-1:0] p, input int k);
    return PH_W'((32'(p) + 32'(k)) % 32'(NUM_PHASES));
  endfunction

  always_comb begin
    cur_oh        = '0;
    cur_oh[cur_q] = 1'b1;
  end

  assign pv    = preempt && (32'(preempt_phase) < 32'(NUM_PHASES));
  assign other = |(pend_q & ~cur_oh);

  // Next phase: preempt target, else the nearest pending phase after the
  // current one (searched downward so the smallest offset wins), else cur+1.
  always_comb begin
    nxt_phase = ph_add(cur_q, 1);
    for (int k = NUM_PHASES - 1; k >= 1; k--) begin
      if (pend_q[ph_add(cur_q, k)]) nxt_phase = ph_add(cur_q, k);
    end
    if (pv) nxt_phase = preempt_phase;
  end

  always_comb begin
    st_d  = st_q;
    cur_d = cur_q;
    case (st_q)
      GREEN: begin
        if ((pv && preempt_phase != cur_q) ||
            (!pv && other && ((timer_q >= MIN_G_LAST && !req[cur_q]) ||
                              timer_q >= MAX_G_LAST)))
          st_d = YELLOW;
      end
      YELLOW: begin
        if (timer_q == YEL_LAST) st_d = ALL_RED;
      end
      ALL_RED: begin
        if (timer_q == AR_LAST) begin
          st_d  = GREEN;
          cur_d = nxt_phase;
        end
      end
      default: st_d = GREEN;
    endcase

    if (st_d != st_q)      timer_d = '0;
    else if (&timer_q)     timer_d = timer_q;
    else                   timer_d = timer_q + 1'b1;

    // Demand latches; the served phase's bit is held clear while green, and
    // the phase entering green is cleared even against a same-cycle request.
    pend_d = pend_q | req;
    if (st_q == GREEN) pend_d[cur_q] = 1'b0;
    if (st_q == ALL_RED && st_d == GREEN) pend_d[cur_d] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q    <= GREEN;
      timer_q <= '0;
      cur_q   <= '0;
      pend_q  <= '0;
    end else begin
      st_q    <= st_d;
      timer_q <= timer_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
    end
  end

  assign green     = (st_q == GREEN)  ? cur_oh : '0;
  assign yellow    = (st_q == YELLOW) ? cur_oh : '0;
  assign red       = ~(green | yellow);
  assign cur_phase = cur_q;
  assign state     = st_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
module tb_traffic_phase_ctrl;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic       preempt;
  logic [1:0] preempt_phase;
  logic [3:0] green, yellow, red, pending;
  logic [1:0] cur_phase, state;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  traffic_phase_ctrl dut (
    .clock(clock), .reset(reset), .req(req), .preempt(preempt),
    .preempt_phase(preempt_phase), .green(green), .yellow(yellow), .red(red),
    .cur_phase(cur_phase), .state(state), .pending(pending)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] rq;
    logic       pre;
    logic [1:0] pph;
    int         ncyc;
    logic [3:0] eg, ey;
    logic [1:0] es, ec;
    logic [3:0] ep;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic r, logic [3:0] rq, logic p, logic [1:0] pp,
                              int nc, logic [3:0] g, logic [3:0] y, logic [1:0] s,
                              logic [1:0] c, logic [3:0] pd);
    vec_t v;
    v.name = n; v.rst = r; v.rq = rq; v.pre = p; v.pph = pp; v.ncyc = nc;
    v.eg = g; v.ey = y; v.es = s; v.ec = c; v.ep = pd;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled there too.
  task automatic apply(vec_t v);
    reset = v.rst; req = v.rq; preempt = v.pre; preempt_phase = v.pph;
    repeat (v.ncyc) @(posedge clock);
    #1;
    checks++;
    if ({green, yellow, state, cur_phase, pending} !== {v.eg, v.ey, v.es, v.ec, v.ep}) begin
      errors++;
      $display("FAIL %s: got g=%b y=%b st=%b cur=%0d pend=%b expected g=%b y=%b st=%b cur=%0d pend=%b",
               v.name, green, yellow, state, cur_phase, pending,
               v.eg, v.ey, v.es, v.ec, v.ep);
    end
  endtask

  // Lamp invariant every cycle: at most one non-red phase, red is the complement.
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if ($countones(green | yellow) > 1 || red !== ~(green | yellow)) begin
        errors++;
        $display("FAIL invariant: got g=%b y=%b r=%b expected onehot and r=~(g|y)",
                 green, yellow, red);
      end
    end
  end

  initial begin
    reset = 1'b1; req = '0; preempt = 1'b0; preempt_phase = '0;

    // Cycle n = state visible after n edges following the last reset edge.
    // 1: reset and rest in phase 0
    vecs.push_back(mk("t1_reset",  1, 4'b0000, 0, 0,  2, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0000));
    vecs.push_back(mk("t1_rest50", 0, 4'b0000, 0, 0, 50, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0000));
    // 2: single req[2] pulse -> gap-out at min green
    vecs.push_back(mk("t2_reset",  1, 4'b0000, 0, 0,  2, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0000));
    vecs.push_back(mk("t2_c1",     0, 4'b0000, 0, 0,  1, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0000));
    vecs.push_back(mk("t2_c2_req", 0, 4'b0100, 0, 0,  1, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0100));
    vecs.push_back(mk("t2_c7",     0, 4'b0000, 0, 0,  5, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0100));
    vecs.push_back(mk("t2_y8",     0, 4'b0000, 0, 0,  1, 4'b0000, 4'b0001, 2'd1, 2'd0, 4'b0100));
    vecs.push_back(mk("t2_y10",    0, 4'b0000, 0, 0,  2, 4'b0000, 4'b0001, 2'd1, 2'd0, 4'b0100));
    vecs.push_back(mk("t2_ar11",   0, 4'b0000, 0, 0,  1, 4'b0000, 4'b0000, 2'd2, 2'd0, 4'b0100));
    vecs.push_back(mk("t2_ar12",   0, 4'b0000, 0, 0,  1, 4'b0000, 4'b0000, 2'd2, 2'd0, 4'b0100));
    vecs.push_back(mk("t2_g13",    0, 4'b0000, 0, 0,  1, 4'b0100, 4'b0000, 2'd0, 2'd2, 4'b0000));
    vecs.push_back(mk("t2_rest",   0, 4'b0000, 0, 0, 30, 4'b0100, 4'b0000, 2'd0, 2'd2, 4'b0000));
    // 3: req[0] held, req[1] pulsed -> max-out
    vecs.push_back(mk("t3_reset",  1, 4'b0000, 0, 0,  2, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0000));
    vecs.push_back(mk("t3_c1",     0, 4'b0011, 0, 0,  1, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0010));
    vecs.push_back(mk("t3_c19",    0, 4'b0001, 0, 0, 18, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0010));
    vecs.push_back(mk("t3_y20",    0, 4'b0001, 0, 0,  1, 4'b0000, 4'b0001, 2'd1, 2'd0, 4'b0010));
    vecs.push_back(mk("t3_ar24",   0, 4'b0001, 0, 0,  4, 4'b0000, 4'b0000, 2'd2, 2'd0, 4'b0011));
    vecs.push_back(mk("t3_g25",    0, 4'b0001, 0, 0,  1, 4'b0010, 4'b0000, 2'd0, 2'd1, 4'b0001));
    // 5: preempt to phase 3, hold, release with pending[0]; then preempt on served phase
    vecs.push_back(mk("t5_reset",  1, 4'b0000, 0, 0,  2, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0000));
    vecs.push_back(mk("t5_c3",     0, 4'b0000, 0, 0,  3, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0000));
    vecs.push_back(mk("t5_y4",     0, 4'b0000, 1, 3,  1, 4'b0000, 4'b0001, 2'd1, 2'd0, 4'b0000));
    vecs.push_back(mk("t5_ar8",    0, 4'b0000, 1, 3,  4, 4'b0000, 4'b0000, 2'd2, 2'd0, 4'b0000));
    vecs.push_back(mk("t5_g9",     0, 4'b0000, 1, 3,  1, 4'b1000, 4'b0000, 2'd0, 2'd3, 4'b0000));
    vecs.push_back(mk("t5_req0",   0, 4'b0001, 1, 3,  1, 4'b1000, 4'b0000, 2'd0, 2'd3, 4'b0001));
    vecs.push_back(mk("t5_hold40", 0, 4'b0000, 1, 3, 30, 4'b1000, 4'b0000, 2'd0, 2'd3, 4'b0001));
    vecs.push_back(mk("t5_rel_y",  0, 4'b0000, 0, 0,  1, 4'b0000, 4'b1000, 2'd1, 2'd3, 4'b0001));
    vecs.push_back(mk("t5_g46",    0, 4'b0000, 0, 0,  5, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0000));
    vecs.push_back(mk("t5_own_rq", 0, 4'b0010, 1, 0,  1, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0010));
    vecs.push_back(mk("t5_own_hd", 0, 4'b0000, 1, 0, 30, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0010));
    vecs.push_back(mk("t5_own_mx", 0, 4'b0000, 0, 0,  1, 4'b0000, 4'b0001, 2'd1, 2'd0, 4'b0010));
    // 6: reset during yellow, then timer restarts from zero
    vecs.push_back(mk("t6_reset",  1, 4'b0000, 0, 0,  2, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0000));
    vecs.push_back(mk("t6_c1",     0, 4'b0100, 0, 0,  1, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0100));
    vecs.push_back(mk("t6_y8",     0, 4'b0000, 0, 0,  7, 4'b0000, 4'b0001, 2'd1, 2'd0, 4'b0100));
    vecs.push_back(mk("t6_y9",     0, 4'b0000, 0, 0,  1, 4'b0000, 4'b0001, 2'd1, 2'd0, 4'b0100));
    vecs.push_back(mk("t6_midrst", 1, 4'b0000, 0, 0,  1, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0000));
    vecs.push_back(mk("t6_c1b",    0, 4'b0010, 0, 0,  1, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0010));
    vecs.push_back(mk("t6_c7b",    0, 4'b0000, 0, 0,  6, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0010));
    vecs.push_back(mk("t6_y8b",    0, 4'b0000, 0, 0,  1, 4'b0000, 4'b0001, 2'd1, 2'd0, 4'b0010));
    // 7: preempt raised during yellow: clearance completes, then preempt beats pending
    vecs.push_back(mk("t7_reset",  1, 4'b0000, 0, 0,  2, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0000));
    vecs.push_back(mk("t7_c1",     0, 4'b0010, 0, 0,  1, 4'b0001, 4'b0000, 2'd0, 2'd0, 4'b0010));
    vecs.push_back(mk("t7_y8",     0, 4'b0000, 0, 0,  7, 4'b0000, 4'b0001, 2'd1, 2'd0, 4'b0010));
    vecs.push_back(mk("t7_ar12",   0, 4'b0000, 1, 3,  4, 4'b0000, 4'b0000, 2'd2, 2'd0, 4'b0010));
    vecs.push_back(mk("t7_g13",    0, 4'b0000, 1, 3,  1, 4'b1000, 4'b0000, 2'd0, 2'd3, 4'b0010));

    @(posedge clock);
    #1;
    mon_en = 1'b1;
    foreach (vecs[i]) apply(vecs[i]);

    // 4: phases 1 and 3 demand continuously -> 1 -> 3 -> 1, phases 0/2 skipped
    begin
      int bad;
      bad = 0;
      reset = 1'b1; req = 4'b0000; preempt = 1'b0; preempt_phase = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0; req = 4'b1010;
      for (int c = 1; c <= 63; c++) begin
        @(posedge clock);
        #1;
        if (c >= 13 && (green[0] || green[2])) bad++;
        if (c == 13) chk("t4_g1_c13",  {28'd0, green},  32'h2);
        if (c == 33) chk("t4_y1_c33",  {28'd0, yellow}, 32'h2);
        if (c == 38) chk("t4_g3_c38",  {28'd0, green},  32'h8);
        if (c == 58) chk("t4_y3_c58",  {28'd0, yellow}, 32'h8);
        if (c == 63) chk("t4_g1_c63",  {28'd0, green},  32'h2);
      end
      chk("t4_skip_0_2", 32'(bad), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
